sparse_pe: RTL and testbench
============================

SPARSE_PE -- requirements
Module: sparse_pe

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- IA_ROW, 8, input-map rows
- IA_COL, 8, input-map columns
- IA_CHANNEL, 8, max compressed IA entries and output channels
- IA_DATA_BITWIDTH, 16, signed IA data and output width
- IA_C_BITWIDTH, 8, IA channel-index width
- W_DATA_BITWIDTH, 16, signed weight width
- W_C_LENGTH, 8, max compressed weight entries
- W_C_BITWIDTH, 8, weight channel-index width
- W_POS_PTR_BITWIDTH, 4, row-pointer width
- W_R_LENGTH, 16, max weight rows
- W_R_BITWIDTH, 2, kernel-row index width
- W_K_BITWIDTH, 3, output-channel index width
REQ-002 SHALL have these ports (name, direction, width, meaning); clock and reset are fixed as: one clock; reset is synchronous and active-high.
- i_clk, in, 1, rising-edge clock
- i_rst, in, 1, synchronous active-high reset
- i_start, in, 1, start pulse
- i_ia_h, in, clog2(IA_ROW)+1, IA row position
- i_ia_w, in, clog2(IA_COL)+1, IA column position
- i_ia_data[IA_CHANNEL], in, IA_DATA_BITWIDTH each, signed nonzero activations
- i_ia_c_idx[IA_CHANNEL], in, IA_C_BITWIDTH each, channel of each activation
- i_ia_iters, in, clog2(IA_CHANNEL)+1, IA entry limit
- i_ia_len, in, clog2(IA_CHANNEL)+1, valid IA entries
- i_w_s, in, 2, kernel column
- i_w_data[W_C_LENGTH], in, W_DATA_BITWIDTH each, signed nonzero weights
- i_w_c_idx[W_C_LENGTH], in, W_C_BITWIDTH each, channel of each weight
- i_pos_ptr[W_R_LENGTH], in, W_POS_PTR_BITWIDTH each, exclusive end index of each weight row
- i_r_idx[W_R_LENGTH], in, W_R_BITWIDTH each, kernel row of each weight row
- i_k_idx[W_R_LENGTH], in, W_K_BITWIDTH each, output channel of each weight row
- i_w_iters, in, clog2(W_C_LENGTH)+1, valid weight rows
- i_w_len, in, clog2(W_C_LENGTH)+1, valid weight entries
- o_finish, out, 1, one-cycle done pulse
- o_output_feature[3*IA_CHANNEL], out, IA_DATA_BITWIDTH each, signed partial sums, index r*IA_CHANNEL+k

Function
REQ-003 SHALL have FSM states IDLE, CALC, DONE; i_start is sampled only in IDLE and ignored elsewhere.
REQ-004 On i_start in IDLE: latch all inputs; clear all outputs; La=min(i_ia_iters,i_ia_len,IA_CHANNEL); Lw=min(i_w_len,W_C_LENGTH); Rn=min(i_w_iters,W_R_LENGTH); go to CALC, or to DONE if La*Lw==0.
REQ-005 Weight row p covers entries [i_pos_ptr[p-1], i_pos_ptr[p]), with the start of row 0 equal to 0; entries at or beyond Lw, or not covered by a row p<Rn, contribute nothing.
REQ-006 CALC SHALL visit one (j,i) pair per cycle: j=0..Lw-1 outer, i=0..La-1 inner, N=La*Lw cycles total.
REQ-007 For each pair with i_ia_c_idx[i]==i_w_c_idx[j], and j in row p with r=i_r_idx[p], k=i_k_idx[p]: out[r*IA_CHANNEL+k] += ia_data[i]*w_data[j].
REQ-008 The product SHALL be a full-precision signed product; accumulation SHALL truncate to IA_DATA_BITWIDTH with two's-complement wrap and no saturation.
REQ-009 A contribution SHALL be discarded if r>2, k>=IA_CHANNEL, i_w_s>2, i_ia_h>=IA_ROW or i_ia_w>=IA_COL.
REQ-010 After the last pair, go to DONE; DONE asserts o_finish (registered) for exactly one cycle, then returns to IDLE.
REQ-011 Timing: with i_start sampled at edge 0, o_finish SHALL be high between edges N+1 and N+2; for N=0, between edges 1 and 2.
REQ-012 o_output_feature SHALL change only during CALC and on start-clear, and SHALL hold its final values until the next accepted i_start.
REQ-013 i_start asserted in the same cycle as o_finish is ignored; i_start accepted in the following IDLE cycle starts a new job.

Reset
REQ-014 i_rst high at a rising edge SHALL force IDLE, o_finish=0, all o_output_feature=0 and all counters=0, including mid-CALC; i_start is ignored while i_rst is high.

Verification
REQ-015 No channel match: h=w=4, s=1, La=2 (data 1,2; c 2,3), Lw=4 (data 4..7; c 5..8), ptr 3,4, r 0,1, k 0,0, w_iters=2 -> all outputs 0; o_finish after edge 9.
REQ-016 Single match: ia (3,c5), w (-2,c5), ptr[0]=1, r=1, k=2, all lengths 1 -> out[IA_CHANNEL+2]=-6, others 0; o_finish after edge 2.
REQ-017 Two rows: ia (2,c1),(5,c3); w (10,c1),(1,c3),(7,c3); ptr 2,3; r 0,2; k 1,1 -> out[1]=25, out[2*IA_CHANNEL+1]=35.
REQ-018 Overflow: ia (32767,c0), w (2,c0), 16-bit -> out=-2 (wrapped).
REQ-019 Reset at CALC cycle 3 -> next cycle outputs 0, o_finish 0, state IDLE; new i_start runs normally.
REQ-020 i_w_len=0 with i_start -> o_finish after edge 1, outputs 0; i_start during CALC -> no effect.

Source files
------------

// File: rtl/sparse_pe.sv
// Sparse convolution processing element: multiplies compressed activations by compressed
// weight rows, accumulating matching-channel products into 3 x IA_CHANNEL partial sums.
module sparse_pe #(
    parameter int IA_ROW             = 8,
    parameter int IA_COL             = 8,
    parameter int IA_CHANNEL         = 8,
    parameter int IA_DATA_BITWIDTH   = 16,
    parameter int IA_C_BITWIDTH      = 8,
    parameter int W_DATA_BITWIDTH    = 16,
    parameter int W_C_LENGTH         = 8,
    parameter int W_C_BITWIDTH       = 8,
    parameter int W_POS_PTR_BITWIDTH = 4,
    parameter int W_R_LENGTH         = 16,
    parameter int W_R_BITWIDTH       = 2,
    parameter int W_K_BITWIDTH       = 3
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [$clog2(IA_ROW):0]             i_ia_h,
    input  logic [$clog2(IA_COL):0]             i_ia_w,
    input  logic signed [IA_DATA_BITWIDTH-1:0]  i_ia_data [IA_CHANNEL],
    input  logic [IA_C_BITWIDTH-1:0]            i_ia_c_idx [IA_CHANNEL],
    input  logic [$clog2(IA_CHANNEL):0]         i_ia_iters,
    input  logic [$clog2(IA_CHANNEL):0]         i_ia_len,
    input  logic [1:0]                          i_w_s,
    input  logic signed [W_DATA_BITWIDTH-1:0]   i_w_data [W_C_LENGTH],
    input  logic [W_C_BITWIDTH-1:0]             i_w_c_idx [W_C_LENGTH],
    input  logic [W_POS_PTR_BITWIDTH-1:0]       i_pos_ptr [W_R_LENGTH],
    input  logic [W_R_BITWIDTH-1:0]             i_r_idx [W_R_LENGTH],
    input  logic [W_K_BITWIDTH-1:0]             i_k_idx [W_R_LENGTH],
    input  logic [$clog2(W_C_LENGTH):0]         i_w_iters,
    input  logic [$clog2(W_C_LENGTH):0]         i_w_len,
    output logic                                o_finish,
    output logic signed [IA_DATA_BITWIDTH-1:0]  o_output_feature [3*IA_CHANNEL]
);
    localparam int LA_W  = $clog2(IA_CHANNEL) + 1;
    localparam int LW_W  = $clog2(W_C_LENGTH) + 1;
    localparam int RN_W  = $clog2(W_R_LENGTH) + 1;
    localparam int AI_W  = $clog2(IA_CHANNEL);
    localparam int WI_W  = $clog2(W_C_LENGTH);
    localparam int RS_W  = $clog2(W_R_LENGTH);
    localparam int NOUT  = 3 * IA_CHANNEL;
    localparam int PW    = IA_DATA_BITWIDTH + W_DATA_BITWIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t                              state_q;
    logic                                finish_q;
    logic signed [IA_DATA_BITWIDTH-1:0]  out_q [NOUT];
    logic [LA_W-1:0]                     la_q, i_q;
    logic [LW_W-1:0]                     lw_q, j_q;
    logic [RN_W-1:0]                     rn_q;

    logic [$clog2(IA_ROW):0]             h_q;
    logic [$clog2(IA_COL):0]             w_q;
    logic [1:0]                          s_q;
    logic signed [IA_DATA_BITWIDTH-1:0]  ia_data_q [IA_CHANNEL];
    logic [IA_C_BITWIDTH-1:0]            ia_c_q [IA_CHANNEL];
    logic signed [W_DATA_BITWIDTH-1:0]   w_data_q [W_C_LENGTH];
    logic [W_C_BITWIDTH-1:0]             w_c_q [W_C_LENGTH];
    logic [W_POS_PTR_BITWIDTH-1:0]       pos_ptr_q [W_R_LENGTH];
    logic [W_R_BITWIDTH-1:0]             r_idx_q [W_R_LENGTH];
    logic [W_K_BITWIDTH-1:0]             k_idx_q [W_R_LENGTH];

    logic                                accept;
    int                                  la_c, lw_c, rn_c;
    int                                  row_start [W_R_LENGTH];
    logic                                row_hit;
    logic [RS_W-1:0]                     row_sel;
    logic [W_R_BITWIDTH-1:0]             r_sel;
    logic [W_K_BITWIDTH-1:0]             k_sel;
    logic signed [PW-1:0]                prod;
    int                                  acc_idx;
    logic                                acc_en;
    logic                                last_i, last_j;

    assign accept = !i_rst && (state_q == IDLE) && i_start && !finish_q;

    always_comb begin
        la_c = int'(i_ia_iters);
        if (int'(i_ia_len) < la_c) la_c = int'(i_ia_len);
        if (IA_CHANNEL < la_c) la_c = IA_CHANNEL;
        lw_c = int'(i_w_len);
        if (W_C_LENGTH < lw_c) lw_c = W_C_LENGTH;
        rn_c = int'(i_w_iters);
        if (W_R_LENGTH < rn_c) rn_c = W_R_LENGTH;
    end

    // Find the lowest valid weight row whose [start, end) range covers entry j.
    always_comb begin
        row_start[0] = 0;
        for (int p = 1; p < W_R_LENGTH; p++) row_start[p] = int'(pos_ptr_q[p-1]);
        row_hit = 1'b0;
        row_sel = '0;
        for (int p = W_R_LENGTH - 1; p >= 0; p--) begin
            if (p < int'(rn_q) && int'(j_q) >= row_start[p] &&
                int'(j_q) < int'(pos_ptr_q[p])) begin
                row_hit = 1'b1;
                row_sel = RS_W'(p);
            end
        end
    end

    always_comb begin
        r_sel   = r_idx_q[row_sel];
        k_sel   = k_idx_q[row_sel];
        prod    = ia_data_q[i_q[AI_W-1:0]] * w_data_q[j_q[WI_W-1:0]];
        acc_idx = int'(r_sel) * IA_CHANNEL + int'(k_sel);
        acc_en  = (state_q == CALC) && row_hit &&
                  (ia_c_q[i_q[AI_W-1:0]] == w_c_q[j_q[WI_W-1:0]]) &&
                  (int'(r_sel) <= 2) && (int'(k_sel) < IA_CHANNEL) && (int'(s_q) <= 2) &&
                  (int'(h_q) < IA_ROW) && (int'(w_q) < IA_COL);
        last_i  = (i_q == la_q - 1'b1);
        last_j  = (j_q == lw_q - 1'b1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            finish_q <= 1'b0;
            la_q     <= '0;
            lw_q     <= '0;
            rn_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            for (int n = 0; n < NOUT; n++) out_q[n] <= '0;
        end else begin
            finish_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        la_q <= LA_W'(la_c);
                        lw_q <= LW_W'(lw_c);
                        rn_q <= RN_W'(rn_c);
                        i_q  <= '0;
                        j_q  <= '0;
                        for (int n = 0; n < NOUT; n++) out_q[n] <= '0;
                        state_q <= (la_c == 0 || lw_c == 0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    for (int n = 0; n < NOUT; n++) begin
                        if (acc_en && n == acc_idx) begin
                            out_q[n] <= out_q[n] + prod[IA_DATA_BITWIDTH-1:0];
                        end
                    end
                    if (last_i) begin
                        i_q <= '0;
                        if (last_j) state_q <= DONE;
                        else        j_q <= j_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                DONE: begin
                    finish_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Job operands are captured once at acceptance so the caller may change inputs mid-job.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            h_q       <= i_ia_h;
            w_q       <= i_ia_w;
            s_q       <= i_w_s;
            ia_data_q <= i_ia_data;
            ia_c_q    <= i_ia_c_idx;
            w_data_q  <= i_w_data;
            w_c_q     <= i_w_c_idx;
            pos_ptr_q <= i_pos_ptr;
            r_idx_q   <= i_r_idx;
            k_idx_q   <= i_k_idx;
        end
    end

    assign o_finish         = finish_q;
    assign o_output_feature = out_q;

endmodule

// File: tb/tb_sparse_pe.sv
// Directed self-checking bench for sparse_pe: hand-computed outputs and finish timing.
module tb_sparse_pe;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [3:0]         ia_h, ia_w;
    logic signed [15:0] ia_data [8];
    logic [7:0]         ia_c [8];
    logic [3:0]         ia_iters, ia_len;
    logic [1:0]         w_s;
    logic signed [15:0] w_data [8];
    logic [7:0]         w_c [8];
    logic [3:0]         ptr [16];
    logic [1:0]         r_idx [16];
    logic [2:0]         k_idx [16];
    logic [3:0]         w_iters, w_len;
    logic               finish;
    logic signed [15:0] ofm [24];

    int checks   = 0;
    int failures = 0;
    int exp_of [24];

    sparse_pe dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ia_h(ia_h), .i_ia_w(ia_w),
        .i_ia_data(ia_data), .i_ia_c_idx(ia_c), .i_ia_iters(ia_iters), .i_ia_len(ia_len),
        .i_w_s(w_s), .i_w_data(w_data), .i_w_c_idx(w_c), .i_pos_ptr(ptr), .i_r_idx(r_idx),
        .i_k_idx(k_idx), .i_w_iters(w_iters), .i_w_len(w_len), .o_finish(finish),
        .o_output_feature(ofm)
    );

    always #5 clk = ~clk;

    task automatic chk(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        for (int n = 0; n < 24; n++) chk(int'(ofm[n]), exp_of[n], $sformatf("%s_out%0d", tag, n));
    endtask

    task automatic clear_exp();
        for (int n = 0; n < 24; n++) exp_of[n] = 0;
    endtask

    task automatic zero_inputs();
        ia_h = 0; ia_w = 0; w_s = 0; ia_iters = 0; ia_len = 0; w_iters = 0; w_len = 0;
        for (int n = 0; n < 8; n++) begin
            ia_data[n] = 0; ia_c[n] = 0; w_data[n] = 0; w_c[n] = 0;
        end
        for (int n = 0; n < 16; n++) begin
            ptr[n] = 0; r_idx[n] = 0; k_idx[n] = 0;
        end
    endtask

    // Two IA entries, three weights in two rows; expects out[1]=25, out[17]=35.
    task automatic cfg_two_rows();
        zero_inputs();
        ia_data[0] = 2; ia_c[0] = 1; ia_data[1] = 5; ia_c[1] = 3;
        ia_iters = 2; ia_len = 2;
        w_data[0] = 10; w_c[0] = 1; w_data[1] = 1; w_c[1] = 3; w_data[2] = 7; w_c[2] = 3;
        ptr[0] = 2; ptr[1] = 3; r_idx[0] = 0; r_idx[1] = 2; k_idx[0] = 1; k_idx[1] = 1;
        w_iters = 2; w_len = 3;
    endtask

    task automatic cfg_single();
        zero_inputs();
        ia_data[0] = 3; ia_c[0] = 5; w_data[0] = -2; w_c[0] = 5;
        ptr[0] = 1; r_idx[0] = 1; k_idx[0] = 2;
        ia_iters = 1; ia_len = 1; w_iters = 1; w_len = 1;
    endtask

    // Start a job at edge 0; optionally re-pulse start before edge 'poke'.
    task automatic run_job(input int exp_edge, input int poke, input string tag);
        int seen;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        seen = -1;
        for (int e = 1; e <= 300 && seen < 0; e++) begin
            if (e == poke) start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            if (finish) seen = e;
        end
        chk(seen, exp_edge, {tag, "_finish_edge"});
        @(posedge clk); #1;
        chk(int'(finish), 0, {tag, "_finish_width"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        clear_exp();
        chk(int'(finish), 0, "reset_finish");
        chk(int'(dut.state_q), 0, "reset_state");
        chk_outputs("reset");
        @(negedge clk); rst = 1'b0;

        // No channel match: N = 2*4 = 8
        zero_inputs();
        ia_h = 4; ia_w = 4; w_s = 1;
        ia_data[0] = 1; ia_c[0] = 2; ia_data[1] = 2; ia_c[1] = 3; ia_iters = 2; ia_len = 2;
        for (int n = 0; n < 4; n++) begin
            w_data[n] = 16'(4 + n); w_c[n] = 8'(5 + n);
        end
        ptr[0] = 3; ptr[1] = 4; r_idx[0] = 0; r_idx[1] = 1; w_iters = 2; w_len = 4;
        run_job(9, 0, "nomatch");
        clear_exp(); chk_outputs("nomatch");

        cfg_single();
        run_job(2, 0, "single");
        clear_exp(); exp_of[10] = -6; chk_outputs("single");

        cfg_two_rows();
        run_job(7, 0, "tworows");
        clear_exp(); exp_of[1] = 25; exp_of[17] = 35; chk_outputs("tworows");

        // IA limit is the min of iters and len: only ia[0] is used, N = 1*3
        cfg_two_rows(); ia_iters = 1;
        run_job(4, 0, "ia_limit");
        clear_exp(); exp_of[1] = 20; chk_outputs("ia_limit");

        // Weight entry 2 is outside row 0, the only valid row
        cfg_two_rows(); w_iters = 1;
        run_job(7, 0, "row_limit");
        clear_exp(); exp_of[1] = 25; chk_outputs("row_limit");

        cfg_single(); ia_data[0] = 32767; ia_c[0] = 0; w_data[0] = 2; w_c[0] = 0;
        r_idx[0] = 0; k_idx[0] = 0;
        run_job(2, 0, "overflow");
        clear_exp(); exp_of[0] = -2; chk_outputs("overflow");

        cfg_single(); w_s = 3;
        run_job(2, 0, "disc_s");
        clear_exp(); chk_outputs("disc_s");

        cfg_single(); r_idx[0] = 3;
        run_job(2, 0, "disc_r");
        chk_outputs("disc_r");

        cfg_single(); ia_h = 8;
        run_job(2, 0, "disc_h");
        chk_outputs("disc_h");

        // Reset after CALC cycle 3 of the two-row job
        cfg_two_rows();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(int'(ofm[1]), 20, "midcalc_partial");
        chk(int'(dut.state_q), 1, "midcalc_state");
        rst = 1'b1;
        @(posedge clk); #1;
        clear_exp(); chk_outputs("midrst");
        chk(int'(finish), 0, "midrst_finish");
        chk(int'(dut.state_q), 0, "midrst_state");
        start = 1'b1;
        @(posedge clk); #1;
        chk(int'(dut.state_q), 0, "rst_start_ignored");
        start = 1'b0; rst = 1'b0;
        run_job(7, 0, "after_rst");
        exp_of[1] = 25; exp_of[17] = 35; chk_outputs("after_rst");

        // Empty weight list finishes immediately and clears old sums
        cfg_two_rows(); w_len = 0;
        run_job(1, 0, "wlen0");
        clear_exp(); chk_outputs("wlen0");

        cfg_two_rows();
        run_job(7, 3, "poke");
        exp_of[1] = 25; exp_of[17] = 35; chk_outputs("poke");

        // Start held high across the finish cycle: ignored there, accepted the cycle after
        cfg_two_rows(); w_len = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk(int'(finish), 1, "hold_finish");
        chk(int'(dut.state_q), 0, "hold_state_e1");
        @(posedge clk); #1;
        chk(int'(dut.state_q), 0, "hold_ignored");
        chk(int'(finish), 0, "hold_finish_low");
        @(posedge clk); #1;
        chk(int'(dut.state_q), 2, "hold_accepted");
        start = 1'b0;
        @(posedge clk); #1;
        chk(int'(finish), 1, "hold_second_finish");
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
